// File: rtl/wbm_arb.sv
// rtl/wbm_arb.sv - round-robin write-back arbiter with FIFO drain to the register file
// Optional query/bypass port enabled with WBM_ARB_BYPASS_EN.
module wbm_arb #(
  parameter int NB_SRC     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_SRC-1:0]              src_valid_i,
  output logic [NB_SRC-1:0]              src_ready_o,
  input  logic [NB_SRC-1:0]              src_write_i,
  input  logic [NB_SRC*ADDR_WIDTH-1:0]   src_addr_i,
  input  logic [NB_SRC*DATA_WIDTH-1:0]   src_data_i,
  input  logic                           rf_stall_i,
  output logic                           reg_write_o,
  output logic [ADDR_WIDTH-1:0]          reg_addr_o,
  output logic [DATA_WIDTH-1:0]          reg_data_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           idle_o
`ifdef WBM_ARB_BYPASS_EN
  ,
  input  logic [ADDR_WIDTH-1:0]          query_addr_i,
  output logic                           query_hit_o,
  output logic [DATA_WIDTH-1:0]          query_data_o
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;

  logic [SW-1:0]         rr_q;
  logic [SW-1:0]         win;
  logic [NB_SRC-1:0]     grant;
  logic                  any_grant;
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         count_q;
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  full, hs, push, pop;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  // First valid channel at or after the rr pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    win       = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NB_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NB_SRC) idx = idx - NB_SRC;
      if (!any_grant && src_valid_i[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        win        = SW'(idx);
      end
    end
  end

  assign full        = (count_q == CW'(DEPTH));
  assign src_ready_o = grant & {NB_SRC{~full & ~rst_i}};
  assign hs          = |(src_valid_i & src_ready_o);
  assign win_addr    = src_addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_data    = src_data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
  // x0 writes and no-write retirements complete the handshake but never occupy the FIFO.
  assign push        = hs & src_write_i[win] & (win_addr != '0);
  assign pop         = (count_q != '0) & ~rf_stall_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr[wr_q] <= win_addr;
      mem_data[wr_q] <= win_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      reg_write_o <= 1'b0;
      reg_addr_o  <= '0;
      reg_data_o  <= '0;
    end else begin
      if (hs) rr_q <= (int'(win) == NB_SRC - 1) ? '0 : win + SW'(1);
      if (push) wr_q <= wr_q + PW'(1);
      if (pop) begin
        rd_q       <= rd_q + PW'(1);
        reg_addr_o <= mem_addr[rd_q];
        reg_data_o <= mem_data[rd_q];
      end
      reg_write_o <= pop;
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign idle_o  = (count_q == '0) & ~reg_write_o;

`ifdef WBM_ARB_BYPASS_EN
  // Scan oldest to youngest so the youngest match wins; the output register is the oldest.
  always_comb begin
    logic [PW-1:0] p;
    p            = '0;
    query_hit_o  = 1'b0;
    query_data_o = '0;
    if (query_addr_i != '0) begin
      if (reg_write_o && reg_addr_o == query_addr_i) begin
        query_hit_o  = 1'b1;
        query_data_o = reg_data_o;
      end
      for (int i = 0; i < DEPTH; i++) begin
        p = rd_q + PW'(i);
        if (CW'(i) < count_q && mem_addr[p] == query_addr_i) begin
          query_hit_o  = 1'b1;
          query_data_o = mem_data[p];
        end
      end
    end
  end
`endif

endmodule
